// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MDU_START = 2'd1,
      MDU_WAIT  = 2'd2
   } hz_state_e;

   // addi x0, x0, 0 -- what a bubbled or flushed pipeline register holds
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam int MDU_TIMEOUT_DEF = 64;
   localparam int CNT_W_DEF       = 32;

   function automatic logic load_use(
      input logic       memread,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       use_rs2
   );
      logic hit;
      hit = 1'b0;
      if (memread && (rd != 5'd0)) begin
         hit = (rd == rs1) || (use_rs2 && (rd == rs2));
      end else begin
         hit = 1'b0;
      end
      return hit;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; slave is the controller view.
interface hazard_ctrl_if;

   logic [4:0] id_rs1_i;
   logic [4:0] id_rs2_i;
   logic       id_use_rs2_i;
   logic [4:0] ex_rd_i;
   logic       ex_memread_i;
   logic       ex_mdu_op_i;
   logic       ex_branch_taken_i;
   logic       mdu_done_i;

   logic       pc_write_o;
   logic       ifid_write_o;
   logic       ifid_flush_o;
   logic       idex_bubble_o;
   logic       exmem_bubble_o;
   logic       mdu_start_o;
   logic       mdu_err_o;

   modport slave (
      input  id_rs1_i, id_rs2_i, id_use_rs2_i, ex_rd_i, ex_memread_i,
      input  ex_mdu_op_i, ex_branch_taken_i, mdu_done_i,
      output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
      output exmem_bubble_o, mdu_start_o, mdu_err_o
   );

   modport master (
      output id_rs1_i, id_rs2_i, id_use_rs2_i, ex_rd_i, ex_memread_i,
      output ex_mdu_op_i, ex_branch_taken_i, mdu_done_i,
      input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
      input  exmem_bubble_o, mdu_start_o, mdu_err_o
   );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the optional hazard performance counters.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count enabled cycles, holding at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, taken-branch flush, MDU start/done sequencing
// with watchdog. Stall/flush performance counters exist only when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
`ifdef HAZARD_PERF_EN
   ,
   parameter int CNT_W = CNT_W_DEF
`endif
)(
   input logic          clk_i,
   input logic          rst_i,
   hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
`endif
);

   localparam int              WD_W    = $clog2(MDU_TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

   hz_state_e       state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;

   logic pc_write_s;
   logic ifid_write_s;
   logic ifid_flush_s;
   logic idex_bubble_s;
   logic exmem_bubble_s;
   logic mdu_start_s;
   logic lu_hit_s;

   assign lu_hit_s = load_use(hz.ex_memread_i, hz.ex_rd_i, hz.id_rs1_i,
                              hz.id_rs2_i, hz.id_use_rs2_i);

   // Next-state and Mealy output decode
   always_comb begin
      state_d        = state_q;
      wd_d           = wd_q;
      err_d          = err_q;
      pc_write_s     = 1'b1;
      ifid_write_s   = 1'b1;
      ifid_flush_s   = 1'b0;
      idex_bubble_s  = 1'b0;
      exmem_bubble_s = 1'b0;
      mdu_start_s    = 1'b0;

      case (state_q)
         RUN: begin
            wd_d = {WD_W{1'b0}};
            if (hz.ex_mdu_op_i) begin
               pc_write_s     = 1'b0;
               ifid_write_s   = 1'b0;
               exmem_bubble_s = 1'b1;
               state_d        = MDU_START;
            end else if (hz.ex_branch_taken_i) begin
               ifid_flush_s  = 1'b1;
               idex_bubble_s = 1'b1;
            end else if (lu_hit_s) begin
               pc_write_s    = 1'b0;
               ifid_write_s  = 1'b0;
               idex_bubble_s = 1'b1;
            end else begin
               pc_write_s   = 1'b1;
               ifid_write_s = 1'b1;
            end
         end

         MDU_START: begin
            pc_write_s     = 1'b0;
            ifid_write_s   = 1'b0;
            exmem_bubble_s = 1'b1;
            mdu_start_s    = 1'b1;
            wd_d           = {WD_W{1'b0}};
            state_d        = MDU_WAIT;
         end

         MDU_WAIT: begin
            wd_d = wd_q + WD_W'(1);
            // The MDU instruction sits in EX until released; EX/MEM only captures on done
            if (hz.mdu_done_i) begin
               pc_write_s     = 1'b1;
               ifid_write_s   = 1'b1;
               exmem_bubble_s = 1'b0;
               state_d        = RUN;
            end else if (wd_q == WD_LAST) begin
               pc_write_s     = 1'b1;
               ifid_write_s   = 1'b1;
               exmem_bubble_s = 1'b1;
               err_d          = 1'b1;
               state_d        = RUN;
            end else begin
               pc_write_s     = 1'b0;
               ifid_write_s   = 1'b0;
               exmem_bubble_s = 1'b1;
            end
         end

         default: begin
            state_d = RUN;
            wd_d    = {WD_W{1'b0}};
         end
      endcase
   end

   // State, watchdog and sticky error registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= RUN;
         wd_q    <= {WD_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   assign hz.pc_write_o     = pc_write_s;
   assign hz.ifid_write_o   = ifid_write_s;
   assign hz.ifid_flush_o   = ifid_flush_s;
   assign hz.idex_bubble_o  = idex_bubble_s;
   assign hz.exmem_bubble_o = exmem_bubble_s;
   assign hz.mdu_start_o    = mdu_start_s;
   assign hz.mdu_err_o      = err_q;

`ifdef HAZARD_PERF_EN
   hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (!pc_write_s),
      .cnt_o (stall_cnt_o)
   );

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (ifid_flush_s),
      .cnt_o (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-counting reference model. Exercises counters when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int TMO = 8;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if hz_if();

`ifdef HAZARD_PERF_EN
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
`endif

   hazard_ctrl #(
      .MDU_TIMEOUT(TMO)
`ifdef HAZARD_PERF_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .hz    (hz_if)
`ifdef HAZARD_PERF_EN
      , .stall_cnt_o (stall_cnt)
      , .flush_cnt_o (flush_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model: phase -1 = running, 0 = start cycle, k>=1 = k-th wait cycle
   int phase = -1;
   bit err_m = 1'b0;
   int stall_m = 0;
   int flush_m = 0;

   function automatic logic [6:0] outs();
      return {hz_if.pc_write_o, hz_if.ifid_write_o, hz_if.ifid_flush_o, hz_if.idex_bubble_o,
              hz_if.exmem_bubble_o, hz_if.mdu_start_o, hz_if.mdu_err_o};
   endfunction

   function automatic logic [6:0] model_out();
      logic pc = 1'b1, ifid = 1'b1, fl = 1'b0, ib = 1'b0, eb = 1'b0, st = 1'b0;
      bit lu;
      lu = hz_if.ex_memread_i && (hz_if.ex_rd_i != 5'd0) &&
           ((hz_if.ex_rd_i == hz_if.id_rs1_i) ||
            (hz_if.id_use_rs2_i && (hz_if.ex_rd_i == hz_if.id_rs2_i)));
      if (phase < 0) begin
         if (hz_if.ex_mdu_op_i) begin pc = 1'b0; ifid = 1'b0; eb = 1'b1; end
         else if (hz_if.ex_branch_taken_i) begin fl = 1'b1; ib = 1'b1; end
         else if (lu) begin pc = 1'b0; ifid = 1'b0; ib = 1'b1; end
      end else if (phase == 0) begin
         pc = 1'b0; ifid = 1'b0; eb = 1'b1; st = 1'b1;
      end else if (hz_if.mdu_done_i) begin
         eb = 1'b0;
      end else if (phase == TMO) begin
         eb = 1'b1;
      end else begin
         pc = 1'b0; ifid = 1'b0; eb = 1'b1;
      end
      return {pc, ifid, fl, ib, eb, st, err_m};
   endfunction

   task automatic model_clock();
      logic [6:0] e;
      e = model_out();
      if (!e[6] && stall_m < CMAX) stall_m++;
      if (e[4] && flush_m < CMAX) flush_m++;
      if (phase < 0) phase = hz_if.ex_mdu_op_i ? 0 : -1;
      else if (phase == 0) phase = 1;
      else if (hz_if.mdu_done_i) phase = -1;
      else if (phase == TMO) begin phase = -1; err_m = 1'b1; end
      else phase++;
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic use2, input logic mr, input logic mdu,
                         input logic br, input logic done);
      hz_if.id_rs1_i          = rs1;
      hz_if.id_rs2_i          = rs2;
      hz_if.ex_rd_i           = rd;
      hz_if.id_use_rs2_i      = use2;
      hz_if.ex_memread_i      = mr;
      hz_if.ex_mdu_op_i       = mdu;
      hz_if.ex_branch_taken_i = br;
      hz_if.mdu_done_i        = done;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if (outs() !== 7'b1100000) begin
         n_err++; $display("FAIL reset_outs: got %b want %b", outs(), 7'b1100000);
      end
`ifdef HAZARD_PERF_EN
      n_vec++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if (outs() !== 7'b1100000) begin
         n_err++; $display("FAIL idle_outs: got %b want %b", outs(), 7'b1100000);
      end
      @(negedge clk);
   endtask

   task automatic test_load_use();
      logic [6:0] exp_t [4];
      exp_t[0] = 7'b0001000; exp_t[1] = 7'b1100000;
      exp_t[2] = 7'b1100000; exp_t[3] = 7'b0001000;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: set_in(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            1: set_in(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            2: set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            default: set_in(5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         endcase
         #1;
         n_vec++;
         if (outs() !== exp_t[k]) begin
            n_err++; $display("FAIL load_use[%0d]: got %b want %b", k, outs(), exp_t[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rs2_unused();
      set_in(5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      n_vec++;
      if (outs() !== 7'b1100000) begin
         n_err++; $display("FAIL rs2_unused: got %b want %b", outs(), 7'b1100000);
      end
      @(negedge clk);
   endtask

   task automatic test_branch_priority();
      set_in(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      n_vec++;
      if (outs() !== 7'b1111000) begin
         n_err++; $display("FAIL branch_wins: got %b want %b", outs(), 7'b1111000);
      end
      @(negedge clk);
   endtask

   task automatic test_mdu_op();
      logic [6:0] exp_t [8];
      int stalls = 0;
      int starts = 0;
      exp_t[0] = 7'b0000100; exp_t[1] = 7'b0000110;
      for (int k = 2; k < 6; k++) exp_t[k] = 7'b0000100;
      exp_t[6] = 7'b1100000; exp_t[7] = 7'b1100000;
      for (int k = 0; k < 8; k++) begin
         if (k == 0)      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         else if (k < 6)  set_in(5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
         else if (k == 6) set_in(5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
         else             set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         if (!hz_if.pc_write_o) stalls++;
         if (hz_if.mdu_start_o) starts++;
         n_vec++;
         if (outs() !== exp_t[k]) begin
            n_err++; $display("FAIL mdu_seq[%0d]: got %b want %b", k, outs(), exp_t[k]);
         end
         @(negedge clk);
      end
      n_vec++;
      if (stalls != 6 || starts != 1) begin
         n_err++; $display("FAIL mdu_counts: got stalls=%0d starts=%0d want 6/1", stalls, starts);
      end
   endtask

   task automatic test_timeout();
      logic [6:0] e;
      for (int k = 0; k < 12; k++) begin
         set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (k == 0), 1'b0, (k == 10));
         if (k == 0)      e = 7'b0000100;
         else if (k == 1) e = 7'b0000110;
         else if (k < 9)  e = 7'b0000100;
         else if (k == 9) e = 7'b1100100;
         else             e = 7'b1100001;
         #1;
         n_vec++;
         if (outs() !== e) begin
            n_err++; $display("FAIL timeout[%0d]: got %b want %b", k, outs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_mdu();
      for (int k = 0; k < 4; k++) begin
         set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (k == 0), 1'b0, 1'b0);
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (outs() !== 7'b1100000) begin
         n_err++; $display("FAIL reset_mid_mdu: got %b want %b", outs(), 7'b1100000);
      end
`ifdef HAZARD_PERF_EN
      n_vec++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         n_err++; $display("FAIL reset_mid_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, (k == 0));
         #1;
         n_vec++;
         if (outs() !== 7'b1100000) begin
            n_err++; $display("FAIL late_done[%0d]: got %b want %b", k, outs(), 7'b1100000);
         end
         @(negedge clk);
      end
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf_sat();
      rst = 1'b0;
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 43; k++) begin
         if (k < 3 || k >= 23) set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         else                  set_in(5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         if (k == 2 || k == 22 || k == 42) begin
            #1;
            n_vec++;
            if ((k == 2  && (stall_cnt !== 4'd0  || flush_cnt !== 4'd3)) ||
                (k == 22 && (stall_cnt !== 4'd15 || flush_cnt !== 4'd3)) ||
                (k == 42 && (stall_cnt !== 4'd15 || flush_cnt !== 4'd15))) begin
               n_err++;
               $display("FAIL perf_sat[%0d]: got stall=%0d flush=%0d", k, stall_cnt, flush_cnt);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      logic [6:0] e;
      rst = 1'b0;
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      phase = -1; err_m = 1'b0; stall_m = 0; flush_m = 0;
      for (int n = 0; n < 800; n++) begin
         set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 6) == 0));
         #1;
         e = model_out();
         n_vec++;
         if (outs() !== e) begin
            n_err++; $display("FAIL random[%0d]: got %b want %b", n, outs(), e);
         end
`ifdef HAZARD_PERF_EN
         n_vec++;
         if (stall_cnt !== CW'(stall_m) || flush_cnt !== CW'(flush_m)) begin
            n_err++;
            $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d",
                     n, stall_cnt, flush_cnt, stall_m, flush_m);
         end
`endif
         model_clock();
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_rs2_unused();
      test_branch_priority();
      test_mdu_op();
      test_timeout();
      test_reset_mid_mdu();
`ifdef HAZARD_PERF_EN
      test_perf_sat();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
